// File: rtl/edge_arb_pkg.sv
// Shared types and helpers for the edge event arbiter.
// The FSM encoding, default sizes and round-robin winner selection live here.
package edge_arb_pkg;

  localparam int DEF_N_CH  = 4;
  localparam int DEF_OVF_W = 8;
  localparam int MAX_CH    = 16;
  localparam int MAX_IDW   = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } state_e;

  // Requests beyond the real channel count are zero, so scanning modulo MAX_CH
  // picks the same winner as scanning modulo the actual channel count.
  function automatic logic [MAX_IDW-1:0] rr_pick(input logic [MAX_CH-1:0]  req,
                                                 input logic [MAX_IDW-1:0] ptr);
    logic [MAX_IDW-1:0] idx;
    logic               found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int k = 0; k < MAX_CH; k++) begin
      idx = ptr + MAX_IDW'(k);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/edge_capture_cell.sv
// One channel: rising-edge detector plus its pending request flag.
// A rise coinciding with the clear keeps the flag set and is not an overflow.
module edge_capture_cell (
  input  logic clk,
  input  logic rst,
  input  logic data_i,
  input  logic en_i,
  input  logic clr_i,
  output logic pending_o,
  output logic ovf_o
);

  logic d_q;
  logic pending_q;
  logic pending_d;
  logic rise;

  assign rise = data_i & ~d_q & en_i;

  always_comb begin
    pending_d = pending_q;
    if (rise) begin
      pending_d = 1'b1;
    end else if (clr_i) begin
      pending_d = 1'b0;
    end
  end

  assign ovf_o     = rise & pending_q & ~clr_i;
  assign pending_o = pending_q;

  // d_q follows the input even in reset so a level already high gives no edge.
  always_ff @(posedge clk) begin
    d_q <= data_i;
    if (rst) begin
      pending_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
    end
  end

endmodule

// File: rtl/edge_event_arbiter.sv
// Serialises per-channel rising-edge events round-robin onto one valid/ready port.
// Counts edges lost to an already pending request in a saturating counter.
module edge_event_arbiter
  import edge_arb_pkg::*;
#(
  parameter int N_CH  = DEF_N_CH,
  parameter int OVF_W = DEF_OVF_W,
  localparam int IDW  = $clog2(N_CH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  data_in,
  input  logic [N_CH-1:0]  ch_en,
  output logic             evt_valid,
  output logic [IDW-1:0]   evt_id,
  input  logic             evt_ready,
  output logic [N_CH-1:0]  pending,
  output logic [OVF_W-1:0] ovf_count
);

  state_e           state_q, state_d;
  logic             evt_valid_q, evt_valid_d;
  logic [IDW-1:0]   evt_id_q, evt_id_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [OVF_W-1:0] ovf_q, ovf_d;
  logic [N_CH-1:0]  pend;
  logic [N_CH-1:0]  ovf_v;
  logic             hs;

  assign hs = evt_valid_q & evt_ready;

  for (genvar i = 0; i < N_CH; i++) begin : g_cell
    edge_capture_cell u_cell (
      .clk       (clk),
      .rst       (rst),
      .data_i    (data_in[i]),
      .en_i      (ch_en[i]),
      .clr_i     (hs && (evt_id_q == IDW'(i))),
      .pending_o (pend[i]),
      .ovf_o     (ovf_v[i])
    );
  end

  always_comb begin
    state_d     = state_q;
    evt_valid_d = evt_valid_q;
    evt_id_d    = evt_id_q;
    rr_ptr_d    = rr_ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (|pend) begin
          evt_id_d    = IDW'(rr_pick(MAX_CH'(pend), MAX_IDW'(rr_ptr_q)));
          evt_valid_d = 1'b1;
          state_d     = ST_OFFER;
        end
      end
      ST_OFFER: begin
        if (hs) begin
          rr_ptr_d    = (evt_id_q == IDW'(N_CH - 1)) ? '0 : evt_id_q + IDW'(1);
          evt_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // One increment per cycle regardless of how many channels overflow at once.
  always_comb begin
    ovf_d = ovf_q;
    if ((|ovf_v) && (ovf_q != {OVF_W{1'b1}})) begin
      ovf_d = ovf_q + OVF_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      evt_valid_q <= 1'b0;
      evt_id_q    <= '0;
      rr_ptr_q    <= '0;
      ovf_q       <= '0;
    end else begin
      state_q     <= state_d;
      evt_valid_q <= evt_valid_d;
      evt_id_q    <= evt_id_d;
      rr_ptr_q    <= rr_ptr_d;
      ovf_q       <= ovf_d;
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_id    = evt_id_q;
  assign pending   = pend;
  assign ovf_count = ovf_q;

endmodule
